// File: rtl/clock_buf_ctrl.sv
// clock_buf_ctrl -- sequences enable/clear of a gated clock buffer behind an
// MMCM/PLL lock. Lock is synchronized, must hold for SETTLE_CYCLES, then the
// buffer divider is cleared for CLR_CYCLES before the buffer is enabled.
// Loss of lock while running latches FAULT until req is dropped.
//
// Ports:
//   clk      in   control clock, rising edge
//   rst      in   async active-high reset
//   req      in   level request to run the buffered clock (clk domain)
//   lock_in  in   MMCM/PLL lock, asynchronous to clk
//   buf_ena  out  buffer CE
//   buf_clr  out  buffer divider CLR
//   ready    out  buffered clock valid
//   fault    out  lock lost while running
//   state    out  FSM state: IDLE=0 WAIT_LOCK=1 SETTLE=2 CLEAR=3 RUN=4 FAULT=5
module clock_buf_ctrl #(
  parameter int SETTLE_CYCLES = 256,
  parameter int CLR_CYCLES    = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       lock_in,
  output logic       buf_ena,
  output logic       buf_clr,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_SETTLE    = 3'd2,
    S_CLEAR     = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_e;

  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CLR_LOAD    = CNT_WIDTH'(CLR_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 sync1_q, sync2_q;
  logic                 lock_s;
  logic                 buf_ena_q, buf_ena_d;
  logic                 buf_clr_q, buf_clr_d;
  logic                 ready_q, ready_d;
  logic                 fault_q, fault_d;

  assign lock_s = sync2_q;

  // 2-flop synchronizer; the FSM only ever looks at lock_s
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= lock_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      buf_ena_q <= 1'b0;
      buf_clr_q <= 1'b0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      buf_ena_q <= buf_ena_d;
      buf_clr_q <= buf_clr_d;
      ready_q   <= ready_d;
      fault_q   <= fault_d;
    end
  end

  // Next state + counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: if (req) state_d = S_WAIT_LOCK;
      S_WAIT_LOCK: begin
        if (!req) state_d = S_IDLE;
        else if (lock_s) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      S_SETTLE: begin
        if (!req)               state_d = S_IDLE;
        else if (!lock_s)       state_d = S_WAIT_LOCK;
        else if (cnt_q == '0) begin
          state_d = S_CLEAR;
          cnt_d   = CLR_LOAD;
        end else                cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      S_CLEAR: begin
        if (!req)               state_d = S_IDLE;
        else if (!lock_s)       state_d = S_WAIT_LOCK;
        else if (cnt_q == '0)   state_d = S_RUN;
        else                    cnt_d = cnt_q - CNT_WIDTH'(1);
      end
      // req drop wins over simultaneous lock loss: no fault
      S_RUN: begin
        if (!req)         state_d = S_IDLE;
        else if (!lock_s) state_d = S_FAULT;
      end
      S_FAULT: if (!req) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the next state and registered, so they line up
  // with state_q and carry no combinational path from the inputs.
  always_comb begin
    buf_ena_d = 1'b0;
    buf_clr_d = 1'b0;
    ready_d   = 1'b0;
    fault_d   = 1'b0;
    unique case (state_d)
      S_CLEAR: buf_clr_d = 1'b1;
      S_RUN: begin
        buf_ena_d = 1'b1;
        ready_d   = 1'b1;
      end
      S_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  assign buf_ena = buf_ena_q;
  assign buf_clr = buf_clr_q;
  assign ready   = ready_q;
  assign fault   = fault_q;
  assign state   = state_q;

endmodule

// File: doc/clock_buf_ctrl.md
CLOCK_BUF_CTRL -- requirements
Module: clock_buf_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 256, giving the number of clk cycles lock must hold before the buffer is released; legal range 1..2^CNT_WIDTH.
REQ-002 The block SHALL have parameter CLR_CYCLES, default 4, giving the number of clk cycles buf_clr is held high before enable; legal range 1..2^CNT_WIDTH.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the shared down-counter.
REQ-004 clk  input  1  free-running control clock; all logic is on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 req  input  1  level request from software or the parent block to run the buffered clock; synchronous to clk.
REQ-007 lock_in  input  1  MMCM/PLL lock, asynchronous to clk.
REQ-008 buf_ena  output  1  drives the buffer enable (CE) of the controlled clock buffer.
REQ-009 buf_clr  output  1  drives the buffer divider clear (CLR) of the controlled clock buffer.
REQ-010 ready  output  1  high while the buffered clock is valid for downstream logic.
REQ-011 fault  output  1  high after lock was lost while running; cleared only through IDLE.
REQ-012 state  output  3  encoded FSM state for status readback: IDLE=0, WAIT_LOCK=1, SETTLE=2, CLEAR=3, RUN=4, FAULT=5.

Function
REQ-013 lock_in SHALL pass through a 2-flop synchronizer; lock_s below is the synchronizer output, 2-cycle latency, and the FSM never samples lock_in directly.
REQ-014 All outputs SHALL be registered and SHALL be decoded from the current state only (Moore); there is no combinational path from input to output.
REQ-015 Output decode: IDLE, WAIT_LOCK and SETTLE give buf_ena=0, buf_clr=0, ready=0; CLEAR gives buf_clr=1, buf_ena=0, ready=0; RUN gives buf_ena=1, buf_clr=0, ready=1; FAULT gives buf_ena=0, buf_clr=0, ready=0, fault=1.
REQ-016 IDLE SHALL go to WAIT_LOCK when req=1; otherwise it stays in IDLE.
REQ-017 WAIT_LOCK SHALL go to IDLE when req=0; else, when lock_s=1, it goes to SETTLE and loads the counter with SETTLE_CYCLES-1.
REQ-018 SETTLE SHALL behave as follows, in priority order:
  - req=0: go to IDLE.
  - lock_s=0: go to WAIT_LOCK.
  - counter=0: go to CLEAR and load the counter with CLR_CYCLES-1.
  - otherwise: decrement the counter.
  SETTLE therefore lasts exactly SETTLE_CYCLES cycles when lock_s stays high.
REQ-019 CLEAR SHALL behave as follows, in priority order:
  - req=0: go to IDLE.
  - lock_s=0: go to WAIT_LOCK.
  - counter=0: go to RUN.
  - otherwise: decrement the counter.
  buf_clr is therefore high for exactly CLR_CYCLES cycles.
REQ-020 RUN SHALL go to IDLE when req=0, and to FAULT when lock_s=0 while req=1; if both occur in the same cycle, req=0 wins and fault is not set.
REQ-021 FAULT SHALL hold until req=0, then go to IDLE; lock_s returning high does not leave FAULT.
REQ-022 buf_ena and buf_clr SHALL never be high in the same cycle.
REQ-023 The counter SHALL never wrap below 0; the decrement is suppressed at 0.
REQ-024 Dropping req in any state SHALL deassert buf_ena and ready on the next clk edge.

Reset
REQ-025 While rst=1: state=IDLE, counter=0, synchronizer flops=0, and buf_ena=0, buf_clr=0, ready=0, fault=0, state=0.
REQ-026 rst asserted mid-operation, including RUN or CLEAR, SHALL force the reset values immediately, without waiting for clk.
REQ-027 After rst falls, the FSM SHALL re-enter WAIT_LOCK only on a sampled req=1 and SHALL re-qualify lock through the synchronizer.

Verification (SETTLE_CYCLES=8, CLR_CYCLES=2)
REQ-028 lock_in=1 held, then req raised -> state goes 1, then 2 for 8 cycles, then 3 for 2 cycles (buf_clr=1), then 4 with buf_ena=ready=1; buf_clr and buf_ena are never both high.
REQ-029 req=1, lock_in=0 -> state stays 1 indefinitely and all outputs stay 0; lock_in raised -> SETTLE is entered exactly 3 edges after the raise (2 synchronizer + 1 FSM).
REQ-030 lock_in dropped at SETTLE count 4 -> back to WAIT_LOCK with fault=0; lock restored -> the full 8-cycle settle restarts from the beginning.
REQ-031 In RUN, drop lock_in -> FAULT with buf_ena=0 and fault=1; restore lock_in -> stays in FAULT; drop req -> IDLE with fault=0.
REQ-032 In RUN, drop req and lock_s in the same cycle -> IDLE with fault=0.
REQ-033 Assert rst asynchronously in CLEAR -> buf_clr=0 and state=0 before the next clk edge; release rst with req=1 -> the sequence restarts at WAIT_LOCK.
